// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Dynamic branch predictor and mispredict resolver for the 5-stage RISC-V
//   pipeline. It keeps a table of 2-bit saturating counters indexed by
//   pc[IDX_BITS+1:2].
//   - The ID stage gets a zero-latency taken/not-taken prediction.
//   - The EX stage sends the resolved branch back. This block then updates
//     the table, flags a mispredict (flush) and supplies the corrected fetch
//     PC.
//   - It also keeps saturating counts of resolved branches and mispredicts.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous reset, active-low
//   id_branch_i        ID instruction is a conditional branch
//   id_pc_i            PC of the ID instruction
//   predict_o          prediction for the ID branch (1 = taken)
//   ex_branch_i        ID_EX holds a branch
//   ex_predict_i       prediction that was made for the EX branch
//   ex_taken_i         resolved outcome from the EX comparator
//   ex_pc_i            PC of the EX branch
//   ex_pc_plus_four_i  fall-through address of the EX branch
//   ex_branch_addr_i   target address of the EX branch
//   flush_o            mispredict; flushes IF_ID and ID_EX
//   redirect_pc_o      corrected next-fetch PC, meaningful when flush_o=1
//   branch_cnt_o       resolved branches since reset (saturating)
//   mispredict_cnt_o   mispredicts since reset (saturating)
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int          IDX_BITS   = 4,
  parameter logic [1:0]  INIT_STATE = 2'b11,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_branch_i,
  input  logic [31:0]      id_pc_i,
  output logic             predict_o,
  input  logic             ex_branch_i,
  input  logic             ex_predict_i,
  input  logic             ex_taken_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_pc_plus_four_i,
  input  logic [31:0]      ex_branch_addr_i,
  output logic             flush_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]          pht [ENTRIES];
  logic [IDX_BITS-1:0] id_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [1:0]          ex_cur;
  logic                mispredict;
  logic [CNT_W-1:0]    branch_cnt;
  logic [CNT_W-1:0]    mispredict_cnt;

  // The PC bits outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc_i[31:IDX_BITS+2], id_pc_i[1:0],
                            ex_pc_i[31:IDX_BITS+2], ex_pc_i[1:0]};

  assign id_idx = id_pc_i[IDX_BITS+1:2];
  assign ex_idx = ex_pc_i[IDX_BITS+1:2];
  assign ex_cur = pht[ex_idx];

  // The prediction reads the registered table directly. When ID and EX hit
  // the same entry in one cycle, ID therefore sees the pre-update value.
  assign predict_o = id_branch_i & pht[id_idx][1];

  assign mispredict    = ex_branch_i & (ex_predict_i != ex_taken_i);
  assign flush_o       = mispredict & rst_i;
  assign redirect_pc_o = ex_taken_i ? ex_branch_addr_i : ex_pc_plus_four_i;

  // Saturating counter update. Each branch updates the table only once,
  // because a flushed ID_EX arrives with ex_branch_i low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= INIT_STATE;
      end
    end else if (ex_branch_i) begin
      if (ex_taken_i && (ex_cur != 2'b11)) begin
        pht[ex_idx] <= ex_cur + 2'b01;
      end else if (!ex_taken_i && (ex_cur != 2'b00)) begin
        pht[ex_idx] <= ex_cur - 2'b01;
      end
    end
  end

  // Statistics counters. Both stop at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_branch_i && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + CNT_ONE;
      end
      if (mispredict && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + CNT_ONE;
      end
    end
  end

  assign branch_cnt_o     = branch_cnt;
  assign mispredict_cnt_o = mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//   Directed testbench for branch_predict_unit. Every expected value is
//   hand-computed from the counter-state walk of each scenario.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        id_branch_i = 1'b0;
  logic [31:0] id_pc_i = '0;
  logic        predict_o;
  logic        ex_branch_i = 1'b0;
  logic        ex_predict_i = 1'b0;
  logic        ex_taken_i = 1'b0;
  logic [31:0] ex_pc_i = '0;
  logic [31:0] ex_pc_plus_four_i = 32'h4;
  logic [31:0] ex_branch_addr_i = 32'h70;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] branch_cnt_o;
  logic [15:0] mispredict_cnt_o;

  int compared   = 0;
  int mismatched = 0;

  branch_predict_unit #(
    .IDX_BITS  (4),
    .INIT_STATE(2'b11),
    .CNT_W     (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .id_branch_i      (id_branch_i),
    .id_pc_i          (id_pc_i),
    .predict_o        (predict_o),
    .ex_branch_i      (ex_branch_i),
    .ex_predict_i     (ex_predict_i),
    .ex_taken_i       (ex_taken_i),
    .ex_pc_i          (ex_pc_i),
    .ex_pc_plus_four_i(ex_pc_plus_four_i),
    .ex_branch_addr_i (ex_branch_addr_i),
    .flush_o          (flush_o),
    .redirect_pc_o    (redirect_pc_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value and report a
  // mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive ID and EX inputs together. The target is pc+0x70, so PC 0x10
  // gives target 0x80 and fall-through 0x14.
  task automatic applyStimulus(input logic id_br, input logic [31:0] id_pc,
                               input logic ex_br, input logic ex_pred,
                               input logic ex_tk, input logic [31:0] ex_pc);
    id_branch_i       = id_br;
    id_pc_i           = id_pc;
    ex_branch_i       = ex_br;
    ex_predict_i      = ex_pred;
    ex_taken_i        = ex_tk;
    ex_pc_i           = ex_pc;
    ex_pc_plus_four_i = ex_pc + 32'h4;
    ex_branch_addr_i  = ex_pc + 32'h70;
    #1;
  endtask

  // Advance one clock, then settle 1ns past the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Look up a PC with no EX activity, and check the prediction.
  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    applyStimulus(1'b1, pc, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput(tag, {31'b0, predict_o}, {31'b0, exp});
  endtask

  // Resolve one EX branch and check flush and redirect before the edge.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic pred,
                         input logic tk, input logic exp_flush,
                         input logic [31:0] exp_redirect);
    applyStimulus(1'b0, 32'h0, 1'b1, pred, tk, pc);
    checkOutput({tag, "_flush"}, {31'b0, flush_o}, {31'b0, exp_flush});
    checkOutput({tag, "_redir"}, redirect_pc_o, exp_redirect);
    tick();
  endtask

  initial begin
    // Reset: asserted asynchronously before the first clock edge.
    #1 rst_i = 1'b0;
    #1;
    applyStimulus(1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 32'h10);
    checkOutput("rst_predict", {31'b0, predict_o}, 32'h1);
    checkOutput("rst_flush", {31'b0, flush_o}, 32'h0);
    checkOutput("rst_redir", redirect_pc_o, 32'h80);
    checkOutput("rst_bcnt", {16'b0, branch_cnt_o}, 32'h0);
    checkOutput("rst_mcnt", {16'b0, mispredict_cnt_o}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    #1;

    // PC 0x10 sees three not-taken outcomes: 11->10->01->00.
    lookup("p10_a", 32'h10, 1'b1);
    resolve("nt1", 32'h10, 1'b1, 1'b0, 1'b1, 32'h14);
    lookup("p10_b", 32'h10, 1'b1);
    resolve("nt2", 32'h10, 1'b1, 1'b0, 1'b1, 32'h14);
    lookup("p10_c", 32'h10, 1'b0);
    resolve("nt3", 32'h10, 1'b0, 1'b0, 1'b0, 32'h14);
    checkOutput("t2_bcnt", {16'b0, branch_cnt_o}, 32'd3);
    checkOutput("t2_mcnt", {16'b0, mispredict_cnt_o}, 32'd2);

    // Not-taken at 00 keeps 00. Two taken outcomes then reach 10, showing
    // the entry did not wrap.
    resolve("nt4", 32'h10, 1'b0, 1'b0, 1'b0, 32'h14);
    lookup("sat0", 32'h10, 1'b0);
    resolve("tk1", 32'h10, 1'b0, 1'b1, 1'b1, 32'h80);
    lookup("p10_01", 32'h10, 1'b0);
    resolve("tk2", 32'h10, 1'b0, 1'b1, 1'b1, 32'h80);
    lookup("p10_10", 32'h10, 1'b1);

    // Taken at 11 keeps 11. Two not-taken outcomes then reach 01.
    resolve("tk30", 32'h30, 1'b1, 1'b1, 1'b0, 32'hA0);
    resolve("nt30a", 32'h30, 1'b1, 1'b0, 1'b1, 32'h34);
    lookup("p30_10", 32'h30, 1'b1);
    resolve("nt30b", 32'h30, 1'b1, 1'b0, 1'b1, 32'h34);
    lookup("p30_01", 32'h30, 1'b0);

    // ID and EX hit the same entry (10) in one cycle: ID sees the old value.
    resolve("nt20", 32'h20, 1'b1, 1'b0, 1'b1, 32'h24);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 32'h20);
    checkOutput("same_predict", {31'b0, predict_o}, 32'h1);
    checkOutput("same_flush", {31'b0, flush_o}, 32'h1);
    tick();
    lookup("p20_after", 32'h20, 1'b0);

    // No branch in EX: no flush and no update. Redirect is still driven,
    // and the prediction is gated by id_branch_i.
    applyStimulus(1'b0, 32'h10, 1'b0, 1'b1, 1'b0, 32'h10);
    checkOutput("nobr_flush", {31'b0, flush_o}, 32'h0);
    checkOutput("nobr_redir", redirect_pc_o, 32'h14);
    checkOutput("nobr_predict", {31'b0, predict_o}, 32'h0);
    tick();
    checkOutput("t5_bcnt", {16'b0, branch_cnt_o}, 32'd11);
    checkOutput("t5_mcnt", {16'b0, mispredict_cnt_o}, 32'd8);
    lookup("p10_kept", 32'h10, 1'b1);

    // Reset in the middle of a mispredicting EX branch.
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 32'h20);
    checkOutput("pre_rst_flush", {31'b0, flush_o}, 32'h1);
    rst_i = 1'b0;
    #1;
    checkOutput("mid_rst_flush", {31'b0, flush_o}, 32'h0);
    checkOutput("mid_rst_bcnt", {16'b0, branch_cnt_o}, 32'h0);
    checkOutput("mid_rst_mcnt", {16'b0, mispredict_cnt_o}, 32'h0);
    checkOutput("mid_rst_p20", {31'b0, predict_o}, 32'h1);
    tick();
    rst_i = 1'b1;
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_rst_bcnt", {16'b0, branch_cnt_o}, 32'h0);
    checkOutput("post_rst_p30", {31'b0, predict_o}, 32'h1);

    // More than 0xFFFF correctly predicted branches: branch_cnt holds 0xFFFF.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40);
    repeat (65534) tick();
    checkOutput("cnt_fffe", {16'b0, branch_cnt_o}, 32'hFFFE);
    repeat (4) tick();
    checkOutput("cnt_sat", {16'b0, branch_cnt_o}, 32'hFFFF);
    checkOutput("cnt_sat_m", {16'b0, mispredict_cnt_o}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
